// File: rtl/ship_placement_ctrl_pkg.sv
// Shared constants, state encoding and fleet table for the ship placement controller.
// Ship 0 is placed first; lengths come from SHIP_LEN in index order.
package ship_placement_ctrl_pkg;

    localparam int BOARD_DIM  = 8;
    localparam int NUM_SHIPS  = 3;
    localparam int SAMPLE_GAP = 4;
    localparam int MAX_RETRY  = 15;
    localparam int MAX_LEN    = 3;
    localparam int GAP_W      = $clog2(SAMPLE_GAP);
    localparam int RETRY_W    = $clog2(MAX_RETRY + 1);

    localparam logic HORIZ = 1'b0;
    localparam logic VERT  = 1'b1;

    localparam logic [1:0] SHIP_LEN [NUM_SHIPS] = '{2'd3, 2'd2, 2'd2};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ROW = 3'd1,
        WAIT_COL = 3'd2,
        CHECK    = 3'd3,
        COMMIT   = 3'd4,
        DONE     = 3'd5,
        FAIL     = 3'd6
    } state_t;

    // Out-of-range ship indices map to length 0, which the checker never accepts.
    function automatic logic [1:0] ship_len(input logic [1:0] idx);
        ship_len = 2'd0;
        for (int i = 0; i < NUM_SHIPS; i++) begin
            if (idx == 2'(i)) begin
                ship_len = SHIP_LEN[i];
            end
        end
    endfunction

endpackage

// File: rtl/ship_placement_ctrl_placement_checker.sv
// Combinational fit test for one candidate ship: stays on the board and
// touches no occupied cell.
module placement_checker
    import ship_placement_ctrl_pkg::*;
(
    input  logic [2:0]  row,
    input  logic [2:0]  col,
    input  logic        dir,
    input  logic [1:0]  len,
    input  logic [63:0] occupancy,
    output logic        fits
);

    logic [3:0]         tail;
    logic               in_bounds;
    logic [MAX_LEN-1:0] hit;

    // Tail coordinate is one bit wider than the board index so it cannot wrap.
    always_comb begin
        tail      = ((dir == VERT) ? {1'b0, row} : {1'b0, col}) + {2'b00, len} - 4'd1;
        in_bounds = (len != 2'd0) && (tail <= 4'(BOARD_DIM - 1));
    end

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cell
            logic [2:0] cell_row;
            logic [2:0] cell_col;
            logic [5:0] cell_idx;
            assign cell_row = (dir == VERT)  ? row + 3'(gi) : row;
            assign cell_col = (dir == HORIZ) ? col + 3'(gi) : col;
            assign cell_idx = 6'({3'b000, cell_row} * 6'(BOARD_DIM)) + {3'b000, cell_col};
            assign hit[gi]  = (2'(gi) < len) && occupancy[cell_idx];
        end
    endgenerate

    assign fits = in_bounds && (hit == '0);

endmodule

// File: rtl/ship_placement_ctrl.sv
// Places the fleet on the 8x8 board from the shared random source, retrying
// rejected candidates and streaming accepted cells to the board RAM.
module ship_placement_ctrl
    import ship_placement_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  rnd_pos,
    input  logic        rnd_dir,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        wr_en,
    output logic [2:0]  wr_row,
    output logic [2:0]  wr_col,
    output logic [1:0]  wr_ship,
    output logic [63:0] occupancy
);

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [1:0]         ship_q, ship_d;
    logic [1:0]         cell_q, cell_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic               dir_q, dir_d;
    logic [63:0]        occ_q, occ_d;
    logic [2:0]         last_row_q, last_row_d;
    logic [2:0]         last_col_q, last_col_d;
    logic [1:0]         last_ship_q, last_ship_d;

    logic [1:0] len;
    logic       fits;
    logic       gap_last;
    logic [2:0] cell_row;
    logic [2:0] cell_col;
    logic [5:0] cell_idx;

    assign len      = ship_len(ship_q);
    assign gap_last = (gap_q == GAP_W'(SAMPLE_GAP - 1));
    assign cell_row = (dir_q == VERT)  ? row_q + {1'b0, cell_q} : row_q;
    assign cell_col = (dir_q == HORIZ) ? col_q + {1'b0, cell_q} : col_q;
    assign cell_idx = 6'({3'b000, cell_row} * 6'(BOARD_DIM)) + {3'b000, cell_col};

    placement_checker u_checker (
        .row       (row_q),
        .col       (col_q),
        .dir       (dir_q),
        .len       (len),
        .occupancy (occ_q),
        .fits      (fits)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            retry_q     <= '0;
            ship_q      <= '0;
            cell_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            dir_q       <= HORIZ;
            occ_q       <= '0;
            last_row_q  <= '0;
            last_col_q  <= '0;
            last_ship_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            retry_q     <= retry_d;
            ship_q      <= ship_d;
            cell_q      <= cell_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dir_q       <= dir_d;
            occ_q       <= occ_d;
            last_row_q  <= last_row_d;
            last_col_q  <= last_col_d;
            last_ship_q <= last_ship_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        retry_d     = retry_q;
        ship_d      = ship_q;
        cell_d      = cell_q;
        row_d       = row_q;
        col_d       = col_q;
        dir_d       = dir_q;
        occ_d       = occ_q;
        last_row_d  = last_row_q;
        last_col_d  = last_col_q;
        last_ship_d = last_ship_q;

        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    occ_d   = '0;
                    ship_d  = '0;
                    retry_d = '0;
                    gap_d   = '0;
                    state_d = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (gap_last) begin
                    row_d   = rnd_pos;
                    gap_d   = '0;
                    state_d = WAIT_COL;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            WAIT_COL: begin
                if (gap_last) begin
                    col_d   = rnd_pos;
                    dir_d   = rnd_dir;
                    gap_d   = '0;
                    state_d = CHECK;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            CHECK: begin
                if (fits) begin
                    cell_d  = '0;
                    state_d = COMMIT;
                end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
                    state_d = FAIL;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = WAIT_ROW;
                end
            end
            COMMIT: begin
                occ_d[cell_idx] = 1'b1;
                last_row_d      = cell_row;
                last_col_d      = cell_col;
                last_ship_d     = ship_q;
                if (cell_q == len - 2'd1) begin
                    if (ship_q == 2'(NUM_SHIPS - 1)) begin
                        state_d = DONE;
                    end else begin
                        ship_d  = ship_q + 2'd1;
                        retry_d = '0;
                        state_d = WAIT_ROW;
                    end
                end else begin
                    cell_d = cell_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write address is live during COMMIT and otherwise holds the last written cell.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        fail      = 1'b0;
        wr_en     = 1'b0;
        wr_row    = last_row_q;
        wr_col    = last_col_q;
        wr_ship   = last_ship_q;
        occupancy = occ_q;
        case (state_q)
            WAIT_ROW, WAIT_COL, CHECK: busy = 1'b1;
            COMMIT: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_row  = cell_row;
                wr_col  = cell_col;
                wr_ship = ship_q;
            end
            DONE:    done = 1'b1;
            FAIL:    fail = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Directed bench for ship_placement_ctrl: the stimulus thread queues expected
// board writes and end-of-run status; a monitor pops and compares them.
module tb_ship_placement_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  rnd_pos = 3'd0;
    logic        rnd_dir = 1'b0;
    logic        busy, done, fail, wr_en;
    logic [2:0]  wr_row, wr_col;
    logic [1:0]  wr_ship;
    logic [63:0] occupancy;

    ship_placement_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rnd_pos   (rnd_pos),
        .rnd_dir   (rnd_dir),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_ship   (wr_ship),
        .occupancy (occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic       dir;
        bit         acc;
    } att_t;

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic [1:0] ship;
    } wr_t;

    typedef struct {
        bit          is_fail;
        logic [63:0] occ;
        int          lat;
    } st_t;

    att_t vec[$];
    wr_t  wr_q[$];
    st_t  st_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int start_edge = 0;
    bit arm = 1'b0;
    int blen [3] = '{3, 2, 2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_row"}, 64'(wr_row), 64'd0);
        chk({tag, "_wr_col"}, 64'(wr_col), 64'd0);
        chk({tag, "_wr_ship"}, 64'(wr_ship), 64'd0);
        chk({tag, "_occ"}, occupancy, 64'd0);
    endtask

    // Monitor: compares every presented write and every done/fail rise.
    initial begin : monitor
        bit term_prev;
        wr_t w;
        st_t s;
        term_prev = 1'b0;
        forever begin
            @(posedge clock);
            edge_cnt++;
            if (start && arm) begin
                start_edge = edge_cnt;
                arm = 1'b0;
            end
            #1;
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr_en", 64'(wr_en), 64'd0);
                end else begin
                    w = wr_q.pop_front();
                    $display("write row=%0d col=%0d ship=%0d (expect %0d,%0d,%0d)",
                             wr_row, wr_col, wr_ship, w.row, w.col, w.ship);
                    chk("wr_row", 64'(wr_row), 64'(w.row));
                    chk("wr_col", 64'(wr_col), 64'(w.col));
                    chk("wr_ship", 64'(wr_ship), 64'(w.ship));
                end
            end
            if ((done || fail) && !term_prev) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_end", 64'(done || fail), 64'd0);
                end else begin
                    s = st_q.pop_front();
                    $display("end done=%0d fail=%0d latency=%0d occ=%016h",
                             done, fail, edge_cnt - start_edge, occupancy);
                    chk("end_done", 64'(done), 64'(!s.is_fail));
                    chk("end_fail", 64'(fail), 64'(s.is_fail));
                    chk("end_busy", 64'(busy), 64'd0);
                    chk("end_occ", occupancy, s.occ);
                    chk("end_latency", 64'(edge_cnt - start_edge), 64'(s.lat));
                end
            end
            term_prev = done || fail;
        end
    end

    // Present each sample only on the cycle it is captured; junk elsewhere.
    task automatic drive_attempt(input att_t a);
        rnd_pos = ~a.row;
        rnd_dir = ~a.dir;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rnd_pos = a.row;
        @(posedge clock);
        @(negedge clock);
        rnd_pos = ~a.col;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rnd_pos = a.col;
        rnd_dir = a.dir;
        @(posedge clock);
        @(negedge clock);
        rnd_pos = ~a.col;
        rnd_dir = ~a.dir;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((st_q.size() != 0 || wr_q.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("queues_drained", 64'(st_q.size() + wr_q.size()), 64'd0);
    endtask

    task automatic run_fleet(input logic [63:0] exp_occ, input int exp_lat,
                             input bit exp_fail, input bit busy_pulse);
        st_t s;
        s.is_fail = exp_fail;
        s.occ     = exp_occ;
        s.lat     = exp_lat;
        st_q.push_back(s);
        @(negedge clock);
        start = 1'b1;
        arm   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_done_clr", 64'(done), 64'd0);
        chk("start_fail_clr", 64'(fail), 64'd0);
        chk("start_occ_clr", occupancy, 64'd0);
        fork
            begin
                int ship;
                wr_t w;
                ship = 0;
                foreach (vec[i]) begin
                    drive_attempt(vec[i]);
                    if (vec[i].acc) begin
                        for (int k = 0; k < blen[ship]; k++) begin
                            w.row  = vec[i].row + ((vec[i].dir == 1'b1) ? 3'(k) : 3'd0);
                            w.col  = vec[i].col + ((vec[i].dir == 1'b0) ? 3'(k) : 3'd0);
                            w.ship = 2'(ship);
                            wr_q.push_back(w);
                        end
                        repeat (blen[ship] + 1) @(posedge clock);
                        ship++;
                    end else begin
                        @(posedge clock);
                    end
                    @(negedge clock);
                end
            end
            begin
                if (busy_pulse) begin
                    repeat (20) @(negedge clock);
                    start = 1'b1;
                    @(negedge clock);
                    start = 1'b0;
                end
            end
        join
        drain();
    endtask

    initial begin : stimulus
        wr_t w;
        repeat (3) @(negedge clock);
        chk_all_zero("in_reset");
        reset = 1'b0;
        @(negedge clock);
        chk_all_zero("after_reset");

        // Basic fleet, plus a start pulse mid-run that must be ignored.
        vec = '{'{3'd0, 3'd0, 1'b0, 1'b1},
                '{3'd2, 3'd5, 1'b1, 1'b1},
                '{3'd7, 3'd6, 1'b0, 1'b1}};
        run_fleet(64'hC000_0000_2020_0007, 34, 1'b0, 1'b1);
        chk("hold_wr_row", 64'(wr_row), 64'd7);
        chk("hold_wr_col", 64'(wr_col), 64'd7);
        chk("hold_wr_ship", 64'(wr_ship), 64'd2);
        chk("hold_occ", occupancy, 64'hC000_0000_2020_0007);

        // Restart from DONE; first ship sample is out of bounds.
        vec = '{'{3'd0, 3'd6, 1'b0, 1'b0},
                '{3'd1, 3'd1, 1'b0, 1'b1},
                '{3'd2, 3'd5, 1'b1, 1'b1},
                '{3'd7, 3'd6, 1'b0, 1'b1}};
        run_fleet(64'hC000_0000_2020_0E00, 43, 1'b0, 1'b0);

        // Overlap rejection of ship 1.
        vec = '{'{3'd4, 3'd4, 1'b0, 1'b1},
                '{3'd3, 3'd5, 1'b1, 1'b0},
                '{3'd5, 3'd0, 1'b0, 1'b1},
                '{3'd7, 3'd6, 1'b0, 1'b1}};
        run_fleet(64'hC000_0370_0000_0000, 43, 1'b0, 1'b0);

        // Retry exhaustion: ship 1 always overlaps ship 0 (16 attempts).
        vec = '{'{3'd0, 3'd0, 1'b0, 1'b1}};
        for (int i = 0; i < 16; i++) vec.push_back('{3'd0, 3'd0, 1'b0, 1'b0});
        run_fleet(64'h0000_0000_0000_0007, 156, 1'b1, 1'b0);
        chk("fail_held", 64'(fail), 64'd1);

        // Reset in the middle of committing ship 0.
        w.row = 3'd0; w.col = 3'd0; w.ship = 2'd0;
        wr_q.push_back(w);
        w.col = 3'd1;
        wr_q.push_back(w);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drive_attempt('{3'd0, 3'd0, 1'b0, 1'b1});
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        chk("mid_commit_writes", 64'(wr_q.size()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk_all_zero("idle_after_reset");

        // From IDLE after reset the fleet places normally again.
        vec = '{'{3'd0, 3'd0, 1'b0, 1'b1},
                '{3'd2, 3'd5, 1'b1, 1'b1},
                '{3'd7, 3'd6, 1'b0, 1'b1}};
        run_fleet(64'hC000_0000_2020_0007, 34, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
